// File: rtl/pipelined_adder.sv
// Carry-pipelined adder, one SEG_WIDTH segment per stage with valid/ready flow.
// Define ADDER_SUB_EN to add the sub port (a - b - c_in mode).
module pipelined_adder #(
   parameter int WIDTH     = 8,
   parameter int SEG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG_WIDTH;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

`ifdef ADDER_SUB_EN
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~c_in : c_in;
`else
   assign b_eff = b;
   assign c_eff = c_in;
`endif

   // x carries a in unprocessed segments and sum bits in finished ones;
   // b shrinks as its low segment is consumed.
   for (genvar s = 0; s < STAGES; s++) begin : g_st
      localparam int RW = WIDTH - s * SEG_WIDTH;

      logic [WIDTH-1:0]   x_i;
      logic [RW-1:0]      b_i;
      logic               c_i;
      logic               v_i;
      logic [SEG_WIDTH:0] seg_sum;
      logic [WIDTH-1:0]   x_d;
      logic [WIDTH-1:0]   x_q;
      logic               c_q;
      logic               v_q;

      if (s == 0) begin : g_src
         assign x_i = a;
         assign b_i = b_eff;
         assign c_i = c_eff;
         assign v_i = in_valid;
      end else begin : g_src
         assign x_i = g_st[s-1].x_q;
         assign b_i = g_st[s-1].g_nxt.b_q;
         assign c_i = g_st[s-1].c_q;
         assign v_i = g_st[s-1].v_q;
      end

      assign seg_sum = {1'b0, x_i[s*SEG_WIDTH +: SEG_WIDTH]}
                     + {1'b0, b_i[SEG_WIDTH-1:0]}
                     + {{SEG_WIDTH{1'b0}}, c_i};

      always_comb begin
         x_d = x_i;
         x_d[s*SEG_WIDTH +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            x_q <= '0;
         end else if (advance) begin
            v_q <= v_i;
            c_q <= seg_sum[SEG_WIDTH];
            x_q <= x_d;
         end
      end

      if (s == STAGES - 1) begin : g_last
         logic ovf_d;
         logic ovf_q;

         // same-sign operands giving a differently signed result
         assign ovf_d = (x_i[WIDTH-1] == b_i[SEG_WIDTH-1])
                     && (seg_sum[SEG_WIDTH-1] != x_i[WIDTH-1]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ovf_q <= 1'b0;
            else if (advance) ovf_q <= ovf_d;
         end
      end else begin : g_nxt
         logic [RW-SEG_WIDTH-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) b_q <= '0;
            else if (advance) b_q <= b_i[RW-1:SEG_WIDTH];
         end
      end
   end

   assign out_valid = g_st[STAGES-1].v_q;
   assign sum       = g_st[STAGES-1].x_q;
   assign c_out     = g_st[STAGES-1].c_q;
   assign ovf       = g_st[STAGES-1].g_last.ovf_q;
   assign advance   = ~(out_valid & ~out_ready);
   assign in_ready  = advance;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at WIDTH=8, SEG_WIDTH=4 (latency 2).
// Subtract vectors run only when ADDER_SUB_EN is defined.
module tb_pipelined_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       c_in;
`ifdef ADDER_SUB_EN
   logic       sub;
`endif
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       c_out;
   logic       ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .SEG_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
`ifdef ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   task automatic drive(input logic [7:0] da, input logic [7:0] db,
                        input logic dc, input logic dv);
      a        = da;
      b        = db;
      c_in     = dc;
      in_valid = dv;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({out_valid, c_out, ovf, sum, in_ready} !== {3'b000, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL reset_pow got v=%b c=%b o=%b s=%h rdy=%b want 0 0 0 00 1",
                  out_valid, c_out, ovf, sum, in_ready);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 drive(8'hAA, 8'h11, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h55, 8'h22, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      checks++;
      if ({out_valid, sum} !== {1'b1, 8'hBB}) begin
         failures++;
         $display("FAIL pre_reset got v=%b s=%h want 1 bb", out_valid, sum);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, c_out, ovf, sum, in_ready} !== {3'b000, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL reset_mid got v=%b c=%b o=%b s=%h rdy=%b want 0 0 0 00 1",
                  out_valid, c_out, ovf, sum, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL reset_flush got v=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_single;
      drive(8'h0F, 8'h01, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h00, 8'h00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_early got v=%b want 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, c_out, ovf, sum} !== {3'b100, 8'h10}) begin
         failures++;
         $display("FAIL single got v=%b c=%b o=%b s=%h want 1 0 0 10",
                  out_valid, c_out, ovf, sum);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_drain got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'hAB, 8'h80};
      logic [7:0] vb [4] = '{8'h01, 8'h01, 8'hCD, 8'h80};
      logic       vc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [10:0] ex [4] = '{{3'b110, 8'h01}, {3'b101, 8'h80},
                             {3'b111, 8'h79}, {3'b111, 8'h00}};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i < 4) drive(va[i], vb[i], vc[i], 1'b1);
         else drive(8'h00, 8'h00, 1'b0, 1'b0);
         #1;
         if (i >= 2) begin
            checks++;
            if ({out_valid, c_out, ovf, sum} !== ex[i-2]) begin
               failures++;
               $display("FAIL b2b_%0d got v=%b c=%b o=%b s=%h want %h",
                        i - 2, out_valid, c_out, ovf, sum, ex[i-2]);
            end
         end
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure;
      @(posedge clk); #1 drive(8'h01, 8'h01, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h02, 8'h02, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h03, 8'h03, 1'b0, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         #1;
         checks++;
         if ({out_valid, sum, in_ready} !== {1'b1, 8'h02, 1'b0}) begin
            failures++;
            $display("FAIL bp_hold_%0d got v=%b s=%h rdy=%b want 1 02 0",
                     i, out_valid, sum, in_ready);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, sum, in_ready} !== {1'b1, 8'h02, 1'b1}) begin
         failures++;
         $display("FAIL bp_release got v=%b s=%h rdy=%b want 1 02 1",
                  out_valid, sum, in_ready);
      end
      @(posedge clk); #1 drive(8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      checks++;
      if ({out_valid, sum} !== {1'b1, 8'h04}) begin
         failures++;
         $display("FAIL bp_second got v=%b s=%h want 1 04", out_valid, sum);
      end
      @(posedge clk); #2;
      checks++;
      if ({out_valid, sum} !== {1'b1, 8'h06}) begin
         failures++;
         $display("FAIL bp_third got v=%b s=%h want 1 06", out_valid, sum);
      end
      @(posedge clk); #2;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_bubbles;
      logic [8:0] ex [4] = '{{1'b1, 8'h30}, {1'b0, 8'h00},
                            {1'b1, 8'h70}, {1'b0, 8'h00}};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i == 0) drive(8'h10, 8'h20, 1'b0, 1'b1);
         else if (i == 2) drive(8'h30, 8'h40, 1'b0, 1'b1);
         else drive(8'h00, 8'h00, 1'b0, 1'b0);
         #1;
         if (i >= 2) begin
            checks++;
            if (out_valid !== ex[i-2][8]
                || (ex[i-2][8] && sum !== ex[i-2][7:0])) begin
               failures++;
               $display("FAIL bubble_%0d got v=%b s=%h want %b %h",
                        i - 2, out_valid, sum, ex[i-2][8], ex[i-2][7:0]);
            end
         end
      end
   endtask

`ifdef ADDER_SUB_EN
   task automatic test_sub;
      sub = 1'b1;
      @(posedge clk); #1 drive(8'h05, 8'h07, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h80, 8'h01, 1'b0, 1'b1);
      @(posedge clk); #1 drive(8'h00, 8'h00, 1'b0, 1'b0);
      sub = 1'b0;
      #1;
      checks++;
      if ({out_valid, c_out, ovf, sum} !== {3'b100, 8'hFE}) begin
         failures++;
         $display("FAIL sub_borrow got v=%b c=%b o=%b s=%h want 1 0 0 fe",
                  out_valid, c_out, ovf, sum);
      end
      @(posedge clk); #2;
      checks++;
      if ({out_valid, c_out, ovf, sum} !== {3'b111, 8'h7F}) begin
         failures++;
         $display("FAIL sub_ovf got v=%b c=%b o=%b s=%h want 1 1 1 7f",
                  out_valid, c_out, ovf, sum);
      end
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
`ifdef ADDER_SUB_EN
      sub       = 1'b0;
`endif
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_bubbles;
`ifdef ADDER_SUB_EN
      test_sub;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
